// File: rtl/boe_reg_bank.sv
// Board control/status register bank: RO ID words, byte-writable scratch/ctrl,
// N alarm channels with live and sticky (W1C) views, and a maskable registered irq.
module boe_reg_bank #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned N_ALARM  = 4,
  parameter logic [31:0] VERSION  = 32'h0000_8000,
  parameter logic [31:0] HW_ID    = 32'h0002_0000,
  parameter logic [31:0] CTRL_RST = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [3:0]            we,
  input  logic [31:0]           din,
  output logic [31:0]           dout,
  input  logic [N_ALARM*32-1:0] alarm_in,
  output logic [31:0]           ctrl_out,
  output logic                  irq
);

  logic rd_req;
  logic wr_req;
  logic [31:0] bmask;

  logic hit_version;
  logic hit_hwid;
  logic hit_scratch;
  logic hit_ctrl;
  logic hit_mask;
  logic hit_status;
  logic [N_ALARM-1:0] hit_raw;
  logic [N_ALARM-1:0] hit_sticky;

  logic [31:0]              dout_q,    dout_d;
  logic [31:0]              scratch_q, scratch_d;
  logic [31:0]              ctrl_q,    ctrl_d;
  logic [N_ALARM-1:0]       mask_q,    mask_d;
  logic [N_ALARM*32-1:0]    alarm_q;
  logic [N_ALARM-1:0][31:0] sticky_q,  sticky_d;
  logic                     irq_q,     irq_d;

  logic [N_ALARM-1:0][31:0] clr;
  logic [N_ALARM-1:0]       status;
  logic [31:0]              rdata;

  assign rd_req = en && (we == 4'b0000);
  assign wr_req = en && (we != 4'b0000);
  assign bmask  = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};

  // Exact full-address compares, so any unaligned or unlisted address misses everything.
  always_comb begin
    hit_version = (addr == ADDR_W'(32'h000));
    hit_hwid    = (addr == ADDR_W'(32'h004));
    hit_scratch = (addr == ADDR_W'(32'h008));
    hit_ctrl    = (addr == ADDR_W'(32'h00C));
    hit_mask    = (addr == ADDR_W'(32'h010));
    hit_status  = (addr == ADDR_W'(32'h014));
    hit_raw     = '0;
    hit_sticky  = '0;
    for (int unsigned i = 0; i < N_ALARM; i++) begin
      hit_raw[i]    = (addr == ADDR_W'(32'h0C0 + 4 * i));
      hit_sticky[i] = (addr == ADDR_W'(32'h100 + 4 * i));
    end
  end

  always_comb begin
    scratch_d = scratch_q;
    ctrl_d    = ctrl_q;
    mask_d    = mask_q;
    if (wr_req && hit_scratch) scratch_d = (scratch_q & ~bmask) | (din & bmask);
    if (wr_req && hit_ctrl)    ctrl_d    = (ctrl_q & ~bmask) | (din & bmask);
    if (wr_req && hit_mask && we[0]) mask_d = din[N_ALARM-1:0];
  end

  // Set from alarm_q is OR-ed in after the clear, so a coincident set wins.
  always_comb begin
    clr      = '0;
    sticky_d = '0;
    status   = '0;
    for (int unsigned i = 0; i < N_ALARM; i++) begin
      if (wr_req && hit_sticky[i]) clr[i] = din & bmask;
      if (wr_req && hit_status && we[0] && din[i]) clr[i] = '1;
      sticky_d[i] = (sticky_q[i] & ~clr[i]) | alarm_q[i*32 +: 32];
      status[i]   = |sticky_q[i];
    end
    irq_d = |(status & mask_q);
  end

  always_comb begin
    rdata = '0;
    if (hit_version)      rdata = VERSION;
    else if (hit_hwid)    rdata = HW_ID;
    else if (hit_scratch) rdata = scratch_q;
    else if (hit_ctrl)    rdata = ctrl_q;
    else if (hit_mask)    rdata = 32'(mask_q);
    else if (hit_status)  rdata = 32'(status);
    else begin
      for (int unsigned i = 0; i < N_ALARM; i++) begin
        if (hit_raw[i])    rdata = alarm_q[i*32 +: 32];
        if (hit_sticky[i]) rdata = sticky_q[i];
      end
    end
    dout_d = rd_req ? rdata : dout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q    <= '0;
      scratch_q <= '0;
      ctrl_q    <= CTRL_RST;
      mask_q    <= '0;
      alarm_q   <= '0;
      sticky_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      dout_q    <= dout_d;
      scratch_q <= scratch_d;
      ctrl_q    <= ctrl_d;
      mask_q    <= mask_d;
      alarm_q   <= alarm_in;
      sticky_q  <= sticky_d;
      irq_q     <= irq_d;
    end
  end

  assign dout     = dout_q;
  assign ctrl_out = ctrl_q;
  assign irq      = irq_q;

endmodule
